// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back sequencer: default widths,
// the hard-wired zero register, and the queued write-back entry layout.
package regfile_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SIZE_DEF  = 5;
  localparam int DEPTH_DEF = 4;
  localparam int ZERO_REG  = 0;

  typedef struct packed {
    logic [SIZE_DEF-1:0]  rd;
    logic [WIDTH_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_sequencer_wb_fifo.sv
// In-order circular buffer of write-back entries: two pushes and one pop per
// cycle, with every slot's rd and live flag exposed for hazard comparison.
module wb_fifo #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 5,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push0_i,
  input  logic [SIZE-1:0]  push0_rd_i,
  input  logic [WIDTH-1:0] push0_data_i,
  input  logic             push1_i,
  input  logic [SIZE-1:0]  push1_rd_i,
  input  logic [WIDTH-1:0] push1_data_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic [SIZE-1:0]  head_rd_o,
  output logic [WIDTH-1:0] head_data_o,
  output logic [SIZE-1:0]  ent_rd_o  [DEPTH],
  output logic             ent_vld_o [DEPTH]
);

  logic [SIZE-1:0]  rd_q   [DEPTH];
  logic [SIZE-1:0]  rd_d   [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] slot1;
  logic [PTR_W-1:0] off [DEPTH];

  always_comb begin
    rd_d    = rd_q;
    data_d  = data_q;
    // The second push lands one slot further along only when the first also pushes.
    slot1   = tail_q + PTR_W'(push0_i);
    if (push0_i) begin
      rd_d[tail_q]   = push0_rd_i;
      data_d[tail_q] = push0_data_i;
    end
    if (push1_i) begin
      rd_d[slot1]   = push1_rd_i;
      data_d[slot1] = push1_data_i;
    end
    tail_d  = tail_q + PTR_W'(push0_i) + PTR_W'(push1_i);
    head_d  = head_q + PTR_W'(pop_i);
    count_d = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      off[i]       = PTR_W'(i) - head_q;
      ent_vld_o[i] = (CNT_W'(off[i]) < count_q);
    end
  end

  assign ent_rd_o    = rd_q;
  assign count_o     = count_q;
  assign head_rd_o   = rd_q[head_q];
  assign head_data_o = data_q[head_q];

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Write-back sequencer: admits ALU and load results into an in-order queue,
// issues one register-file write per cycle and flags pending writes to rs/rt.
module regfile_wb_sequencer
  import regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SIZE  = SIZE_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid_i,
  input  logic [SIZE-1:0]  alu_rd_i,
  input  logic [WIDTH-1:0] alu_data_i,
  output logic             alu_ready_o,
  input  logic             mem_valid_i,
  input  logic [SIZE-1:0]  mem_rd_i,
  input  logic [WIDTH-1:0] mem_data_i,
  output logic             mem_ready_o,
  input  logic [SIZE-1:0]  read_register_1_i,
  input  logic [SIZE-1:0]  read_register_2_i,
  output logic             hazard_1_o,
  output logic             hazard_2_o,
  output logic             reg_write_o,
  output logic [SIZE-1:0]  write_register_o,
  output logic [WIDTH-1:0] write_data_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count;
  logic [SIZE-1:0]  head_rd;
  logic [WIDTH-1:0] head_data;
  logic [SIZE-1:0]  ent_rd  [DEPTH];
  logic             ent_vld [DEPTH];
  logic             mem_push, alu_push, pop;

  logic             wr_en_q, wr_en_d;
  logic [SIZE-1:0]  wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;

  // Readiness ignores a same-cycle pop; the ALU yields the last free slot to a load.
  assign mem_ready_o = (count < CNT_W'(DEPTH));
  assign alu_ready_o = (count <= CNT_W'(DEPTH - 2)) ||
                       ((count == CNT_W'(DEPTH - 1)) && !mem_valid_i);

  // Writes to the zero register are swallowed: handshaken but never queued.
  assign mem_push = mem_valid_i && mem_ready_o && (mem_rd_i != SIZE'(ZERO_REG));
  assign alu_push = alu_valid_i && alu_ready_o && (alu_rd_i != SIZE'(ZERO_REG));
  assign pop      = (count != '0);

  wb_fifo #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push0_i      (mem_push),
    .push0_rd_i   (mem_rd_i),
    .push0_data_i (mem_data_i),
    .push1_i      (alu_push),
    .push1_rd_i   (alu_rd_i),
    .push1_data_i (alu_data_i),
    .pop_i        (pop),
    .count_o      (count),
    .head_rd_o    (head_rd),
    .head_data_o  (head_data),
    .ent_rd_o     (ent_rd),
    .ent_vld_o    (ent_vld)
  );

  always_comb begin
    wr_en_d   = pop;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_addr_d = head_rd;
      wr_data_d = head_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign reg_write_o      = wr_en_q;
  assign write_register_o = wr_addr_q;
  assign write_data_o     = wr_data_q;

  // A write is pending while queued or while it sits in the output register.
  always_comb begin
    hazard_1_o = wr_en_q && (wr_addr_q == read_register_1_i);
    hazard_2_o = wr_en_q && (wr_addr_q == read_register_2_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_rd[i] == read_register_1_i)) hazard_1_o = 1'b1;
      if (ent_vld[i] && (ent_rd[i] == read_register_2_i)) hazard_2_o = 1'b1;
    end
    if (read_register_1_i == SIZE'(ZERO_REG)) hazard_1_o = 1'b0;
    if (read_register_2_i == SIZE'(ZERO_REG)) hazard_2_o = 1'b0;
  end

endmodule
